// File: rtl/dog_subtractor.sv
// Difference-of-Gaussians builder: walks every pixel of two blurred images and
// emits sharper - fuzzier as a signed 9-bit value with a write strobe.
module dog_subtractor #(
  parameter int DIMENSION    = 128,
  parameter int BRAM_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_in,
  input  logic        bram_ready,
  input  logic [7:0]  sharper_pix,
  input  logic [7:0]  fuzzier_pix,
  output logic        busy,
  output logic [13:0] address,
  output logic [8:0]  data_out,
  output logic [1:0]  state_num,
  output logic        wea
);

  // state | meaning
  // IDLE  | waiting for bram_ready, address parked at 0
  // WAIT  | address stable, letting BRAM read data settle
  // WRITE | one-cycle write strobe of the registered difference
  // DONE  | one-cycle tail of the pass before returning to IDLE
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [13:0] LAST_ADDR = 14'(DIMENSION * DIMENSION - 1);
  localparam logic [7:0]  WAIT_LAST = 8'(BRAM_LATENCY - 1);

  state_t      r_state;
  state_t      w_next;
  logic [13:0] r_addr;
  logic [7:0]  r_wait_cnt;
  logic [8:0]  r_data;
  logic        w_wait_done;
  logic        w_last_pix;
  logic [8:0]  w_diff;

  assign w_wait_done = (r_wait_cnt == WAIT_LAST);
  assign w_last_pix  = (r_addr == LAST_ADDR);
  assign w_diff      = {1'b0, sharper_pix} - {1'b0, fuzzier_pix};

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bram_ready) w_next = WAIT;
      WAIT:    if (w_wait_done) w_next = WRITE;
      WRITE:   w_next = w_last_pix ? DONE : WAIT;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      r_state    <= IDLE;
      r_addr     <= 14'd0;
      r_wait_cnt <= 8'd0;
      r_data     <= 9'd0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: begin
          if (bram_ready) begin
            r_addr     <= 14'd0;
            r_wait_cnt <= 8'd0;
          end
        end
        WAIT: begin
          // Difference is captured on the edge that enters WRITE.
          if (w_wait_done) r_data <= w_diff;
          else             r_wait_cnt <= r_wait_cnt + 8'd1;
        end
        WRITE: begin
          if (!w_last_pix) begin
            r_addr     <= r_addr + 14'd1;
            r_wait_cnt <= 8'd0;
          end
        end
        DONE: begin
          r_addr <= 14'd0;
        end
        default: r_addr <= 14'd0;
      endcase
    end
  end

  assign busy      = (r_state != IDLE);
  assign wea       = (r_state == WRITE);
  assign address   = r_addr;
  assign data_out  = r_data;
  assign state_num = r_state;

endmodule

// File: tb/tb_dog_subtractor.sv
// Directed bench for dog_subtractor at DIMENSION=4, BRAM_LATENCY=2.
module tb_dog_subtractor;

  logic        clk;
  logic        rst_in;
  logic        bram_ready;
  logic [7:0]  sharper_pix;
  logic [7:0]  fuzzier_pix;
  logic        busy;
  logic [13:0] address;
  logic [8:0]  data_out;
  logic [1:0]  state_num;
  logic        wea;

  int checks = 0;
  int errors = 0;

  dog_subtractor #(
    .DIMENSION   (4),
    .BRAM_LATENCY(2)
  ) dut (
    .clk        (clk),
    .rst_in     (rst_in),
    .bram_ready (bram_ready),
    .sharper_pix(sharper_pix),
    .fuzzier_pix(fuzzier_pix),
    .busy       (busy),
    .address    (address),
    .data_out   (data_out),
    .state_num  (state_num),
    .wea        (wea)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pixel pattern per scenario: mode 0 basic, 1 negative switch, 2 extremes, 3 restart attempt.
  task automatic set_pix(input int mode, input int idx);
    case (mode)
      1: begin sharper_pix = 8'd42; fuzzier_pix = (idx < 6) ? 8'd23 : 8'd63; end
      2: begin
        if (idx < 5)       begin sharper_pix = 8'd255; fuzzier_pix = 8'd0;   end
        else if (idx < 10) begin sharper_pix = 8'd0;   fuzzier_pix = 8'd255; end
        else               begin sharper_pix = 8'd77;  fuzzier_pix = 8'd77;  end
      end
      3: begin sharper_pix = 8'd100; fuzzier_pix = 8'd1; end
      default: begin sharper_pix = 8'd42; fuzzier_pix = 8'd23; end
    endcase
  endtask

  function automatic logic [8:0] exp_data(input int mode, input int idx);
    case (mode)
      1: return (idx < 6) ? 9'h013 : 9'h1EB;
      2: return (idx < 5) ? 9'h0FF : ((idx < 10) ? 9'h101 : 9'h000);
      3: return 9'h063;
      default: return 9'h013;
    endcase
  endfunction

  task automatic run_pass(input int mode, input string tag);
    int  cyc;
    int  writes;
    int  busy_cycles;
    int  last_w;
    bit  pulsed;
    set_pix(mode, 0);
    @(negedge clk); bram_ready = 1'b1;
    @(negedge clk); bram_ready = 1'b0;
    cyc = 0; writes = 0; busy_cycles = 0; last_w = -1; pulsed = 1'b0;
    while (busy === 1'b1 && cyc < 200) begin
      if (wea === 1'b1) begin
        checks++;
        if (address !== 14'(writes)) begin
          errors++;
          $display("FAIL %s write_addr #%0d: got %0d expected %0d", tag, writes, address, writes);
        end
        checks++;
        if (data_out !== exp_data(mode, writes)) begin
          errors++;
          $display("FAIL %s write_data #%0d: got %h expected %h", tag, writes, data_out, exp_data(mode, writes));
        end
        checks++;
        if ((writes == 0 && cyc != 2) || (writes > 0 && cyc - last_w != 3)) begin
          errors++;
          $display("FAIL %s write_spacing #%0d: got cycle %0d, previous %0d", tag, writes, cyc, last_w);
        end
        last_w = cyc;
        writes++;
        set_pix(mode, writes);
      end
      if (cyc == 48) begin
        checks++;
        if (state_num !== 2'd3 || wea !== 1'b0) begin
          errors++;
          $display("FAIL %s done_state: got state %0d wea %b expected state 3 wea 0", tag, state_num, wea);
        end
      end
      if (mode == 3 && !pulsed && address == 14'd5 && wea === 1'b0) begin
        bram_ready = 1'b1;
        pulsed = 1'b1;
      end
      busy_cycles++;
      cyc++;
      @(negedge clk);
      bram_ready = 1'b0;
    end
    checks++;
    if (busy_cycles != 49) begin
      errors++;
      $display("FAIL %s busy_length: got %0d expected 49", tag, busy_cycles);
    end
    checks++;
    if (writes != 16) begin
      errors++;
      $display("FAIL %s write_count: got %0d expected 16", tag, writes);
    end
    checks++;
    if (busy !== 1'b0 || address !== 14'd0 || state_num !== 2'd0 || wea !== 1'b0) begin
      errors++;
      $display("FAIL %s idle_after: got busy %b addr %0d state %0d wea %b expected 0 0 0 0",
               tag, busy, address, state_num, wea);
    end
  endtask

  task automatic test_reset();
    rst_in = 1'b0; bram_ready = 1'b0; sharper_pix = 8'd0; fuzzier_pix = 8'd0;
    repeat (3) @(negedge clk);
    rst_in = 1'b1;
    set_pix(0, 0);
    @(negedge clk); bram_ready = 1'b1;
    @(negedge clk); bram_ready = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || data_out !== 9'h013) begin
      errors++;
      $display("FAIL reset_prerun: got busy %b data %h expected 1 013", busy, data_out);
    end
    @(posedge clk);
    #3 rst_in = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || address !== 14'd0 || data_out !== 9'd0 || wea !== 1'b0 || state_num !== 2'd0) begin
      errors++;
      $display("FAIL reset_async: got busy %b addr %0d data %h wea %b state %0d expected all 0",
               busy, address, data_out, wea, state_num);
    end
    @(negedge clk); rst_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || address !== 14'd0 || data_out !== 9'd0 || wea !== 1'b0 || state_num !== 2'd0) begin
        errors++;
        $display("FAIL reset_hold cycle %0d: got busy %b addr %0d data %h wea %b state %0d expected all 0",
                 i, busy, address, data_out, wea, state_num);
      end
    end
  endtask

  task automatic test_basic_pass();
    run_pass(0, "basic");
  endtask

  task automatic test_negative();
    run_pass(1, "negative");
  endtask

  task automatic test_extremes();
    run_pass(2, "extremes");
  endtask

  task automatic test_start_ignored();
    run_pass(3, "start_ignored");
    run_pass(0, "second_pass");
  endtask

  task automatic test_reset_mid_pass();
    int  cyc;
    bit  found;
    int  stray;
    set_pix(0, 0);
    @(negedge clk); bram_ready = 1'b1;
    @(negedge clk); bram_ready = 1'b0;
    cyc = 0; found = 1'b0;
    while (!found && cyc < 100) begin
      if (address == 14'd7 && state_num === 2'd1) found = 1'b1;
      else begin
        @(negedge clk);
        cyc++;
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL midreset_reach: got addr %0d state %0d expected addr 7 state 1", address, state_num);
    end
    #2 rst_in = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || wea !== 1'b0 || address !== 14'd0 || state_num !== 2'd0) begin
      errors++;
      $display("FAIL midreset_immediate: got busy %b wea %b addr %0d state %0d expected 0 0 0 0",
               busy, wea, address, state_num);
    end
    @(negedge clk);
    @(negedge clk); rst_in = 1'b1;
    stray = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (wea !== 1'b0 || busy !== 1'b0) stray++;
    end
    checks++;
    if (stray != 0) begin
      errors++;
      $display("FAIL midreset_quiet: got %0d active cycles expected 0", stray);
    end
    run_pass(0, "after_reset");
  endtask

  initial begin
    test_reset();
    test_basic_pass();
    test_negative();
    test_extremes();
    test_start_ignored();
    test_reset_mid_pass();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/dog_subtractor.md
Name: dog_subtractor

Overview:
- Difference-of-Gaussians builder for the SIFT pipeline.
- Walks every pixel address of a DIMENSION x DIMENSION greyscale image held in two read-only BRAMs (sharper and fuzzier blur levels).
- Per pixel, subtracts fuzzier from sharper and presents a signed 9-bit result with a write strobe for an output DoG BRAM at the same address.
- Sits between the Gaussian blur stage and keypoint extraction.

Parameters:
- DIMENSION, 128, image side length in pixels; DIMENSION*DIMENSION must be <= 16384.
- BRAM_LATENCY, 2, read latency in cycles from address to valid pixel data (registered-output BRAM).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_in  input  1  reset, asynchronous, active-low.
- bram_ready  input  1  single-cycle start pulse: source images are valid.
- sharper_pix  input  8  unsigned pixel from the less-blurred image at `address`.
- fuzzier_pix  input  8  unsigned pixel from the more-blurred image at `address`.
- busy  output  1  high from accepted start until the DONE state is left.
- address  output  14  read address for both source BRAMs and write address for the DoG BRAM.
- data_out  output  9  signed difference sharper_pix - fuzzier_pix.
- state_num  output  2  current FSM state encoding, for debug.
- wea  output  1  one-cycle write enable for the DoG BRAM.

Behaviour:
- Reset (rst_in low, asynchronous) forces the following values immediately:
  - state IDLE, busy=0, address=0, data_out=0, wea=0, state_num=0.
  - Internal wait counter = 0.
- Reset mid-operation aborts the current pass; no further writes occur.
- FSM encodings: IDLE=0, WAIT=1, WRITE=2, DONE=3. state_num always equals the current encoding.
- IDLE:
  - A rising edge with bram_ready=1 sets busy=1, address=0, clears the wait counter and moves to WAIT.
  - bram_ready is ignored in every other state.
- WAIT:
  - Holds address stable while the counter runs for BRAM_LATENCY cycles, then moves to WRITE.
  - wea=0 throughout.
- WRITE (exactly one cycle):
  - wea=1.
  - data_out = {1'b0,sharper_pix} - {1'b0,fuzzier_pix}, two's complement 9-bit, range -255..+255, no saturation.
  - data_out is registered on entry to WRITE and held until the next WRITE.
  - address is unchanged during WRITE, so the write lands at the pixel just read.
  - Next state:
    - If address == DIMENSION*DIMENSION-1, go to DONE.
    - Otherwise address increments by 1, the counter clears, and go to WAIT.
- Per-pixel cost is BRAM_LATENCY+1 cycles. A full pass takes DIMENSION*DIMENSION*(BRAM_LATENCY+1) cycles plus 1 DONE cycle.
- DONE (one cycle):
  - wea=0 and busy=1.
  - Next state is IDLE, where busy=0 and address returns to 0.
- No wrap-around: the address never exceeds DIMENSION*DIMENSION-1 within a pass.
- A new pass requires a fresh bram_ready pulse while in IDLE.

Test Plan:
- Reset: assert rst_in low asynchronously mid-cycle -> all outputs 0 immediately, state_num=0; release and hold bram_ready=0 for 5 cycles -> outputs stay 0.
- Basic pass (DIMENSION=4, BRAM_LATENCY=2), sharper=42, fuzzier=23 constant, bram_ready pulsed 1 cycle:
  - Exactly 16 wea pulses at addresses 0..15, spaced 3 cycles apart.
  - data_out=19 (9'h013) on every pulse.
  - busy high for 49 cycles, then low.
- Negative result: switch to sharper=42, fuzzier=63 partway through -> subsequent writes carry data_out=-21 (9'h1EB); earlier writes carry 19.
- Extremes: sharper=255, fuzzier=0 -> +255 (9'h0FF); sharper=0, fuzzier=255 -> -255 (9'h101); equal inputs -> 0.
- Start ignored while busy: pulse bram_ready again at address 5 -> the pass continues unchanged with 16 writes total and no restart; after DONE, a new pulse starts a second full pass from address 0.
- Reset mid-pass: drop rst_in during WAIT at address 7 -> wea never asserts again, busy=0 immediately; a later bram_ready restarts from address 0.
